// File: rtl/oai_nm_pipe.sv
// oai_nm_pipe: pipelined OR-AND-INVERT block.
// ZN = NOT( AND over groups of ( OR over the inputs in that group ) ).
// The function is evaluated combinationally at the input and then carried
// through LATENCY register stages. The last stage is the output register:
// it holds ZN across bubbles and drives VLD_OUT. A saturating counter
// tracks how many valid results came out low.
module oai_nm_pipe #(
  parameter int GROUPS  = 2,
  parameter int INPUTS  = 3,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [GROUPS*INPUTS-1:0]   A,
  input  logic                       VLD_IN,
  input  logic                       HOLD,
  input  logic                       CLR_CNT,
  output logic                       ZN,
  output logic                       VLD_OUT,
  output logic [CNT_W-1:0]           LOW_CNT
);

  // Out-of-range parameters stop elaboration instead of building odd hardware.
  if (GROUPS < 1 || GROUPS > 8) begin : g_chk_groups
    $error("oai_nm_pipe: GROUPS must be in 1..8");
  end
  if (INPUTS < 1 || INPUTS > 8) begin : g_chk_inputs
    $error("oai_nm_pipe: INPUTS must be in 1..8");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_chk_latency
    $error("oai_nm_pipe: LATENCY must be in 1..4");
  end
  if (CNT_W < 1 || CNT_W > 16) begin : g_chk_cnt_w
    $error("oai_nm_pipe: CNT_W must be in 1..16");
  end

  logic [GROUPS-1:0] or_vec;
  logic              res_in;

  // Signals entering the output register (from the input or the last inner stage).
  logic              feed_vld;
  logic              feed_res;

  // OR each group, AND the group results, invert.
  always_comb begin
    or_vec = '0;
    for (int g = 0; g < GROUPS; g++) begin
      or_vec[g] = |A[g*INPUTS +: INPUTS];
    end
    res_in = ~(&or_vec);
  end

  if (LATENCY == 1) begin : g_no_pipe
    assign feed_vld = VLD_IN;
    assign feed_res = res_in;
  end else begin : g_pipe
    logic [LATENCY-2:0] pipe_vld;
    logic [LATENCY-2:0] pipe_res;

    // Inner stages shift {valid, res} forward unless frozen by HOLD.
    always_ff @(posedge CLK) begin
      if (RST) begin
        pipe_vld <= '0;
        pipe_res <= '1;
      end else if (!HOLD) begin
        pipe_vld[0] <= VLD_IN;
        pipe_res[0] <= res_in;
        for (int k = 1; k < LATENCY-1; k++) begin
          pipe_vld[k] <= pipe_vld[k-1];
          pipe_res[k] <= pipe_res[k-1];
        end
      end
    end

    assign feed_vld = pipe_vld[LATENCY-2];
    assign feed_res = pipe_res[LATENCY-2];
  end

  // Output stage: ZN only moves on valid data; VLD_OUT pulses once per result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ZN      <= 1'b1;
      VLD_OUT <= 1'b0;
    end else if (!HOLD) begin
      VLD_OUT <= feed_vld;
      if (feed_vld) begin
        ZN <= feed_res;
      end
    end
  end

  // Low-result counter: clear beats increment, saturates at all ones.
  always_ff @(posedge CLK) begin
    if (RST) begin
      LOW_CNT <= '0;
    end else if (CLR_CNT) begin
      LOW_CNT <= '0;
    end else if (!HOLD && feed_vld && !feed_res && (LOW_CNT != '1)) begin
      LOW_CNT <= LOW_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_oai_nm_pipe.sv
// tb_oai_nm_pipe: scoreboard bench for oai_nm_pipe across several parameter sets.
// All DUTs share the stimulus; a selector routes one DUT to the scoreboard.
module tb_oai_nm_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] a6;
  logic [7:0] a8;
  logic       vld_in;
  logic       hold;
  logic       clr_cnt;

  logic       zn_a, zn_b, zn_c, zn_d, zn_e, zn_f;
  logic       vo_a, vo_b, vo_c, vo_d, vo_e, vo_f;
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_e, cnt_f;
  logic [1:0] cnt_d;

  int         sel;
  logic       zn_sel;
  logic       vld_sel;
  logic [7:0] cnt_sel;

  logic       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         pulses   = 0;
  int         exp_low  = 0;
  logic       hold_prev = 1'b0;

  always #5 clk = ~clk;

  oai_nm_pipe #(.GROUPS(2), .INPUTS(3), .LATENCY(1), .CNT_W(8)) dut_a (
    .CLK(clk), .RST(rst), .A(a6), .VLD_IN(vld_in), .HOLD(hold), .CLR_CNT(clr_cnt),
    .ZN(zn_a), .VLD_OUT(vo_a), .LOW_CNT(cnt_a));
  oai_nm_pipe #(.GROUPS(2), .INPUTS(3), .LATENCY(3), .CNT_W(8)) dut_b (
    .CLK(clk), .RST(rst), .A(a6), .VLD_IN(vld_in), .HOLD(hold), .CLR_CNT(clr_cnt),
    .ZN(zn_b), .VLD_OUT(vo_b), .LOW_CNT(cnt_b));
  oai_nm_pipe #(.GROUPS(2), .INPUTS(3), .LATENCY(2), .CNT_W(8)) dut_c (
    .CLK(clk), .RST(rst), .A(a6), .VLD_IN(vld_in), .HOLD(hold), .CLR_CNT(clr_cnt),
    .ZN(zn_c), .VLD_OUT(vo_c), .LOW_CNT(cnt_c));
  oai_nm_pipe #(.GROUPS(2), .INPUTS(3), .LATENCY(1), .CNT_W(2)) dut_d (
    .CLK(clk), .RST(rst), .A(a6), .VLD_IN(vld_in), .HOLD(hold), .CLR_CNT(clr_cnt),
    .ZN(zn_d), .VLD_OUT(vo_d), .LOW_CNT(cnt_d));
  oai_nm_pipe #(.GROUPS(2), .INPUTS(3), .LATENCY(4), .CNT_W(8)) dut_e (
    .CLK(clk), .RST(rst), .A(a6), .VLD_IN(vld_in), .HOLD(hold), .CLR_CNT(clr_cnt),
    .ZN(zn_e), .VLD_OUT(vo_e), .LOW_CNT(cnt_e));
  oai_nm_pipe #(.GROUPS(4), .INPUTS(2), .LATENCY(1), .CNT_W(8)) dut_f (
    .CLK(clk), .RST(rst), .A(a8), .VLD_IN(vld_in), .HOLD(hold), .CLR_CNT(clr_cnt),
    .ZN(zn_f), .VLD_OUT(vo_f), .LOW_CNT(cnt_f));

  // Route the DUT under test to the scoreboard and direct checks.
  always_comb begin
    zn_sel  = zn_a;
    vld_sel = vo_a;
    cnt_sel = cnt_a;
    case (sel)
      1: begin zn_sel = zn_b; vld_sel = vo_b; cnt_sel = cnt_b; end
      2: begin zn_sel = zn_c; vld_sel = vo_c; cnt_sel = cnt_c; end
      3: begin zn_sel = zn_d; vld_sel = vo_d; cnt_sel = {6'b0, cnt_d}; end
      4: begin zn_sel = zn_e; vld_sel = vo_e; cnt_sel = cnt_e; end
      5: begin zn_sel = zn_f; vld_sel = vo_f; cnt_sel = cnt_f; end
      default: ;
    endcase
  end

  // Reference OAI: bit g*inputs+i is input i of group g.
  function automatic logic oaiModel(input logic [7:0] a, input int groups, input int inputs);
    logic all_or;
    logic one_or;
    all_or = 1'b1;
    for (int g = 0; g < groups; g++) begin
      one_or = 1'b0;
      for (int i = 0; i < inputs; i++) begin
        one_or = one_or | a[g*inputs + i];
      end
      all_or = all_or & one_or;
    end
    return ~all_or;
  endfunction

  task automatic checkOutput(input string tag, input int unsigned actual, input int unsigned expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one cycle of stimulus; valid, unfrozen inputs get an expected result queued.
  task automatic applyStimulus(input logic [5:0] v6, input logic [7:0] v8,
                               input logic v, input logic h, input logic c);
    logic e;
    a6      = v6;
    a8      = v8;
    vld_in  = v;
    hold    = h;
    clr_cnt = c;
    if (v && !h && !rst) begin
      e = (sel == 5) ? oaiModel(v8, 4, 2) : oaiModel({2'b00, v6}, 2, 3);
      exp_q.push_back(e);
      if (!e) exp_low++;
    end
    tick();
  endtask

  task automatic resetAndSelect(input int s);
    rst     = 1'b1;
    vld_in  = 1'b0;
    hold    = 1'b0;
    clr_cnt = 1'b0;
    tick();
    sel = s;
    exp_q.delete();
    exp_low = 0;
    rst = 1'b0;
  endtask

  // HOLD as seen by the last edge, so a frozen VLD_OUT is not counted twice.
  always @(posedge clk) hold_prev = hold;

  // Scoreboard: every fresh VLD_OUT pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (vld_sel && !hold_prev && !rst) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_pulse", 1, 0);
      end else begin
        checkOutput("sb_zn", zn_sel, exp_q.pop_front());
      end
    end
  end

  initial begin
    int p0;
    sel = 0;
    rst = 1'b1; a6 = '0; a8 = '0; vld_in = 1'b0; hold = 1'b0; clr_cnt = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("rst_zn", zn_a, 1);
    checkOutput("rst_vld", vo_a, 0);
    checkOutput("rst_cnt", cnt_a, 0);
    checkOutput("rst_e_zn", zn_e, 1);

    // Truth table on OAI33, LATENCY=1.
    resetAndSelect(0);
    applyStimulus(6'b000_001, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("tt_000001_zn", zn_sel, 1);
    checkOutput("tt_000001_vld", vld_sel, 1);
    applyStimulus(6'b001_001, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("tt_001001_zn", zn_sel, 0);
    applyStimulus(6'b111_000, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("tt_111000_zn", zn_sel, 1);
    for (int v = 0; v < 64; v++) begin
      applyStimulus(6'(v), 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("tt_b2b_vld", vld_sel, 1);
    end
    applyStimulus(6'b000_000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("tt_bubble_vld", vld_sel, 0);
    checkOutput("tt_bubble_zn_hold", zn_sel, 0);
    checkOutput("tt_low_cnt", cnt_sel, exp_low);
    checkOutput("tt_drain", exp_q.size(), 0);

    // Latency and bubbles, LATENCY=3.
    resetAndSelect(1);
    applyStimulus(6'b010_100, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("lat_e1_vld", vld_sel, 0);
    checkOutput("lat_e1_zn", zn_sel, 1);
    applyStimulus(6'b000_000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_e2_vld", vld_sel, 0);
    applyStimulus(6'b000_000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_e3_vld", vld_sel, 1);
    checkOutput("lat_e3_zn", zn_sel, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'b000_000, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("lat_after_vld", vld_sel, 0);
      checkOutput("lat_after_zn", zn_sel, 0);
    end
    checkOutput("lat_cnt", cnt_sel, 1);
    checkOutput("lat_drain", exp_q.size(), 0);

    // HOLD freezes everything, LATENCY=2.
    resetAndSelect(2);
    p0 = pulses;
    applyStimulus(6'b010_100, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(6'b110_011, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_pre_vld", vld_sel, 1);
    checkOutput("hold_pre_cnt", cnt_sel, 1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(6'b111_111, 8'h00, 1'b1, 1'b1, 1'b0);
      checkOutput("hold_frz_vld", vld_sel, 1);
      checkOutput("hold_frz_zn", zn_sel, 0);
      checkOutput("hold_frz_cnt", cnt_sel, 1);
    end
    applyStimulus(6'b000_000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_rel_vld", vld_sel, 1);
    checkOutput("hold_rel_cnt", cnt_sel, 2);
    applyStimulus(6'b000_000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_end_vld", vld_sel, 0);
    applyStimulus(6'b000_000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_cnt_final", cnt_sel, 2);
    checkOutput("hold_pulses", pulses - p0, 2);
    checkOutput("hold_drain", exp_q.size(), 0);

    // Saturation and clear, CNT_W=2.
    resetAndSelect(3);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(6'b010_100, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("sat_cnt", cnt_sel, (k > 3) ? 3 : k);
    end
    applyStimulus(6'b010_100, 8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_wins_cnt", cnt_sel, 0);
    checkOutput("clr_wins_vld", vld_sel, 1);
    applyStimulus(6'b010_100, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("clr_restart_cnt", cnt_sel, 1);
    applyStimulus(6'b000_000, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_during_hold_cnt", cnt_sel, 0);
    applyStimulus(6'b000_000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_drain", exp_q.size(), 0);

    // Reset mid-flight, LATENCY=4.
    resetAndSelect(4);
    applyStimulus(6'b010_100, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(6'b011_001, 8'h00, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    vld_in = 1'b0;
    tick();
    checkOutput("mid_rst_zn", zn_sel, 1);
    checkOutput("mid_rst_vld", vld_sel, 0);
    checkOutput("mid_rst_cnt", cnt_sel, 0);
    rst = 1'b0;
    exp_q.delete();
    p0 = pulses;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(6'b000_000, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("mid_rst_no_pulse", pulses - p0, 0);
    checkOutput("mid_rst_cnt_after", cnt_sel, 0);

    // Generalisation, GROUPS=4, INPUTS=2.
    resetAndSelect(5);
    applyStimulus(6'b000_000, 8'b01_10_11_01, 1'b1, 1'b0, 1'b0);
    checkOutput("gen_01101101_zn", zn_sel, 0);
    applyStimulus(6'b000_000, 8'b00_10_11_01, 1'b1, 1'b0, 1'b0);
    checkOutput("gen_00101101_zn", zn_sel, 1);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(6'b000_000, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(6'b000_000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("gen_cnt", cnt_sel, exp_low);
    checkOutput("gen_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
